bioz_pll_lock_det: RTL and testbench
====================================

# bioz_pll_lock_det

PLL lock detector for the BioZ clock generator. Runs on the VCO clock, measures the 500 kHz reference period in VCO cycles, and compares the result with the divider ratio used for the PFD feedback (64 at lock: 32 MHz / 500 kHz). It raises `Locked` after a run of in-tolerance periods and flags a missing reference. It is the measuring end of the divider path: the divider produces Fin/64, and this block confirms that Fin/Fref actually equals 64.

## Interface
Parameters:
- `N_TARGET`, default 64: expected Fin cycles per Fref period.
- `TOL`, default 2: allowed absolute deviation, inclusive.
- `LOCK_CNT`, default 4: number of consecutive good periods required to assert `Locked`.
- `UNLOCK_CNT`, default 2: number of consecutive bad periods required to drop `Locked`.
- `CNT_W`, default 8: period counter width; `CNT_MAX` = 2^CNT_W − 1.

Ports:
- `Fin` in 1: VCO clock; the block's only clock; rising edge.
- `Resetn` in 1: reset; asynchronous, active-low.
- `Fref` in 1: reference clock, asynchronous to `Fin`.
- `En` in 1: detector enable, synchronous.
- `Meas` out CNT_W: last completed period count.
- `Meas_valid` out 1: one-cycle pulse when `Meas` updates.
- `Locked` out 1: lock indicator.
- `Ref_lost` out 1: no reference edge seen within `CNT_MAX` cycles.

## Operation
- `Fref` passes through a 2-flop synchronizer and then an edge register. `ref_edge` = s2 & ~s3, where s3 is the delayed copy of s2.
- FSM states:
  - IDLE: waits for `En`=1, then moves to SYNC.
  - SYNC: waits for the first `ref_edge`. That edge starts a period but does not produce a measurement. Sets cnt<=1 and moves to MEAS.
  - MEAS: each cycle, cnt<=cnt+1, saturating at `CNT_MAX`.
- On `ref_edge` in MEAS:
  - `Meas`<=cnt, `Meas_valid`<=1, cnt<=1.
  - The period is good if |cnt − N_TARGET| ≤ TOL, computed in CNT_W+1 bits, signed.
  - Good: good_run++ (saturating at LOCK_CNT), bad_run<=0. `Locked`<=1 when good_run reaches LOCK_CNT.
  - Bad: bad_run++ (saturating), good_run<=0. `Locked`<=0 when bad_run reaches UNLOCK_CNT.
  - `Ref_lost`<=0.
- If cnt==CNT_MAX in MEAS and there is no `ref_edge`:
  - `Ref_lost`<=1, `Locked`<=0, good_run<=0, bad_run<=0.
  - Return to SYNC. `Meas_valid` is not pulsed and `Meas` holds.
- If `ref_edge` arrives in the same cycle that cnt==CNT_MAX, it is treated as a normal edge and the measured period is CNT_MAX.
- `En`=0 in any state:
  - Next state is IDLE; `Locked`, `Ref_lost`, good_run, bad_run and cnt are cleared.
  - `Meas` holds.
  - `En`=0 has priority over a coincident `ref_edge` or saturation.
- Synchronizer flops run regardless of `En`.

## Timing
- Every flop clears asynchronously on `Resetn`=0. Outputs during and after reset: `Meas`=0, `Meas_valid`=0, `Locked`=0, `Ref_lost`=0. FSM goes to IDLE.
- Fref rise to `ref_edge`: 2–3 Fin cycles, depending on synchronizer phase. Because this latency is constant it cancels out of the measured period, so `Meas` has ±1 cycle quantization.
- `Meas`, `Meas_valid`, `Locked` and `Ref_lost` all update on the Fin edge following the `ref_edge` cycle; all are registered outputs.
- Minimum time to `Locked` from `En` rise: 1 sync edge + LOCK_CNT periods, i.e. about 5 × 64 Fin cycles.
- Ref-lost detection: `Ref_lost` rises CNT_MAX cycles after the last accepted edge, plus 1 cycle.

## Structure
- Package `bioz_pll_pkg` holds:
  - the state enum {IDLE, SYNC, MEAS};
  - default constants for N_TARGET, TOL, LOCK_CNT, UNLOCK_CNT, CNT_W.
- Sub-module `bioz_pll_ref_sync` contains the 2-flop synchronizer plus rising-edge detect on `Fref`. It has its own `Fin`/`Resetn` and outputs `ref_edge`.
- Top level holds the FSM, period counter, tolerance compare and run counters.

## Test plan
- Reset: assert `Resetn`=0 mid-MEAS with `Locked`=1. Required response:
  - all outputs go to 0 immediately, without waiting for a clock;
  - after release, `Locked` stays 0 until 4 new good periods are measured.
- Nominal lock: `En`=1, Fref period = 64 Fin cycles. Required response:
  - no `Meas_valid` on the first edge;
  - every later edge gives `Meas`=64;
  - `Locked` rises with the 4th `Meas_valid`.
- Tolerance: while locked, apply periods of 66 and then 62. Required response: `Locked` stays 1.
- Unlock hysteresis, while locked:
  - one 67 followed by 64: `Locked` stays 1;
  - 67 then 67: `Locked` drops with the second `Meas_valid`.
- Ref loss: hold Fref low after lock. Required response:
  - `Ref_lost`=1 and `Locked`=0 at 256 cycles after the last edge;
  - `Meas` holds 64;
  - when Fref restarts, `Ref_lost` clears at the first `Meas_valid` after the sync edge.
- Enable: drop `En` mid-period while `Locked`=1. Required response:
  - next cycle `Locked`=0 and `Meas` holds;
  - on re-enable, the detector re-syncs and needs 4 good periods before `Locked` rises again.

Source files
------------

// File: rtl/bioz_pll_pkg.sv
// Purpose : shared types and default constants for the BioZ PLL lock detector.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package bioz_pll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    MEAS = 2'd2
  } state_t;

  // 32 MHz VCO / 500 kHz reference = 64 cycles per reference period at lock.
  localparam int DEF_N_TARGET   = 64;
  localparam int DEF_TOL        = 2;
  localparam int DEF_LOCK_CNT   = 4;
  localparam int DEF_UNLOCK_CNT = 2;
  localparam int DEF_CNT_W      = 8;

  // Width needed to hold the larger of the two run-length thresholds.
  function automatic int run_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/bioz_pll_lock_det_if.sv
// Purpose : reference/enable inputs and measurement/status outputs of the lock detector.
// Latency : n/a (wiring only).
// Backpressure: none; outputs are level/pulse status, no handshake.
// Ports   : Fref, En (master -> detector); Meas, Meas_valid, Locked, Ref_lost (detector -> master).
interface bioz_pll_lock_det_if
  import bioz_pll_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             Fref;
  logic             En;
  logic [CNT_W-1:0] Meas;
  logic             Meas_valid;
  logic             Locked;
  logic             Ref_lost;

  modport master (
    output Fref, En,
    input  Meas, Meas_valid, Locked, Ref_lost
  );

  modport slave (
    input  Fref, En,
    output Meas, Meas_valid, Locked, Ref_lost
  );

endinterface

// File: rtl/bioz_pll_ref_sync.sv
// Purpose : brings the asynchronous reference into the Fin domain and flags its rising edge.
// Latency : Fref rise to ref_edge high is 2-3 Fin cycles depending on phase.
// Backpressure: none; ref_edge is a single-cycle pulse.
// Ports   : Fin (clock), Resetn (async active-low), Fref (async in), ref_edge (1-cycle pulse out).
module bioz_pll_ref_sync
  import bioz_pll_pkg::*;
(
  input  logic Fin,
  input  logic Resetn,
  input  logic Fref,
  output logic ref_edge
);

  logic s1, s2, s3;

  // Runs independently of the detector enable so the edge history is always valid.
  always_ff @(posedge Fin or negedge Resetn) begin
    if (!Resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= Fref;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ref_edge = s2 & ~s3;

endmodule

// File: rtl/bioz_pll_lock_det.sv
// Purpose : measures the Fref period in Fin cycles and declares lock / reference loss.
// Latency : status outputs update on the Fin edge after the internal ref_edge cycle.
// Backpressure: none; Meas_valid is a one-cycle pulse, other outputs are levels.
// Ports   : Fin (VCO clock), Resetn (async active-low), bus (slave: Fref, En in;
//           Meas, Meas_valid, Locked, Ref_lost out).
module bioz_pll_lock_det
  import bioz_pll_pkg::*;
#(
  parameter int N_TARGET   = DEF_N_TARGET,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                Fin,
  input  logic                Resetn,
  bioz_pll_lock_det_if.slave  bus
);

  localparam int RUN_W = run_w(LOCK_CNT, UNLOCK_CNT);

  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic signed [CNT_W:0]   TARGET_S = (CNT_W+1)'(N_TARGET);
  localparam logic signed [CNT_W:0]   TOL_S    = (CNT_W+1)'(TOL);
  localparam logic [RUN_W-1:0]        LOCK_V   = RUN_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0]        UNLOCK_V = RUN_W'(UNLOCK_CNT);
  localparam logic [RUN_W-1:0]        RUN_ONE  = RUN_W'(1);

  logic ref_edge;

  bioz_pll_ref_sync u_ref_sync (
    .Fin      (Fin),
    .Resetn   (Resetn),
    .Fref     (bus.Fref),
    .ref_edge (ref_edge)
  );

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [RUN_W-1:0]   good_run, bad_run;
  logic [RUN_W-1:0]   good_nxt, bad_nxt;
  logic [CNT_W-1:0]   meas_q;
  logic               meas_vld_q, locked_q, ref_lost_q;
  logic signed [CNT_W:0] diff;
  logic               period_good;

  // One extra bit keeps cnt - N_TARGET from wrapping when cnt is small.
  always_comb begin
    diff        = $signed({1'b0, cnt}) - TARGET_S;
    period_good = (diff <= TOL_S) && (diff >= -TOL_S);
    good_nxt    = (good_run == LOCK_V)   ? good_run : good_run + RUN_ONE;
    bad_nxt     = (bad_run  == UNLOCK_V) ? bad_run  : bad_run  + RUN_ONE;
  end

  always_ff @(posedge Fin or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      good_run   <= '0;
      bad_run    <= '0;
      meas_q     <= '0;
      meas_vld_q <= 1'b0;
      locked_q   <= 1'b0;
      ref_lost_q <= 1'b0;
    end else begin
      meas_vld_q <= 1'b0;
      if (!bus.En) begin
        // Disable wins over any coincident edge or saturation; Meas is kept.
        state      <= IDLE;
        cnt        <= '0;
        good_run   <= '0;
        bad_run    <= '0;
        locked_q   <= 1'b0;
        ref_lost_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            // First edge only opens a period; nothing to report yet.
            if (ref_edge) begin
              cnt   <= CNT_ONE;
              state <= MEAS;
            end
          end
          MEAS: begin
            if (ref_edge) begin
              // An edge on the saturation cycle still counts as a real period.
              meas_q     <= cnt;
              meas_vld_q <= 1'b1;
              cnt        <= CNT_ONE;
              ref_lost_q <= 1'b0;
              if (period_good) begin
                good_run <= good_nxt;
                bad_run  <= '0;
                if (good_nxt == LOCK_V) locked_q <= 1'b1;
              end else begin
                bad_run  <= bad_nxt;
                good_run <= '0;
                if (bad_nxt == UNLOCK_V) locked_q <= 1'b0;
              end
            end else if (cnt == CNT_MAX) begin
              ref_lost_q <= 1'b1;
              locked_q   <= 1'b0;
              good_run   <= '0;
              bad_run    <= '0;
              cnt        <= '0;
              state      <= SYNC;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.Meas       = meas_q;
  assign bus.Meas_valid = meas_vld_q;
  assign bus.Locked     = locked_q;
  assign bus.Ref_lost   = ref_lost_q;

endmodule

// File: tb/tb_bioz_pll_lock_det.sv
// Purpose : directed self-checking bench for the PLL lock detector.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_bioz_pll_lock_det;

  logic Fin = 1'b0;
  logic Resetn;

  bioz_pll_lock_det_if #(.CNT_W(8)) bus ();

  bioz_pll_lock_det #(
    .N_TARGET(64), .TOL(2), .LOCK_CNT(4), .UNLOCK_CNT(2), .CNT_W(8)
  ) dut (
    .Fin    (Fin),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Fin = ~Fin;

  int checks   = 0;
  int failures = 0;

  // Results of the most recent reference period driven by pulse().
  int         vld_idx, vld_cnt, rl_rise_idx;
  logic [7:0] meas_at;
  logic       locked_at, rl_at;

  // One Fref period of n Fin cycles: rise at the start, high for n/2 cycles.
  // The rise closes the previous period, so any Meas reported here is the
  // length of the previous pulse() call.
  task automatic pulse(input int n);
    vld_idx = -1; vld_cnt = 0; rl_rise_idx = -1;
    meas_at = '0; locked_at = 1'b0; rl_at = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.Fref = (i < n / 2);
      @(negedge Fin);
      if (bus.Meas_valid === 1'b1) begin
        vld_cnt++;
        if (vld_idx < 0) begin
          vld_idx   = i;
          meas_at   = bus.Meas;
          locked_at = bus.Locked;
          rl_at     = bus.Ref_lost;
        end
      end
      if (bus.Ref_lost === 1'b1 && rl_rise_idx < 0) rl_rise_idx = i;
    end
  endtask

  task automatic test_reset;
    Resetn = 1'b1; bus.En = 1'b0; bus.Fref = 1'b0;
    #1 Resetn = 1'b0;
    #1;
    checks++; if (bus.Meas !== 8'd0) begin failures++; $display("FAIL rst_meas: got %0d expected 0", bus.Meas); end
    checks++; if (bus.Meas_valid !== 1'b0) begin failures++; $display("FAIL rst_vld: got %b expected 0", bus.Meas_valid); end
    checks++; if (bus.Locked !== 1'b0) begin failures++; $display("FAIL rst_locked: got %b expected 0", bus.Locked); end
    checks++; if (bus.Ref_lost !== 1'b0) begin failures++; $display("FAIL rst_reflost: got %b expected 0", bus.Ref_lost); end
    @(negedge Fin); @(negedge Fin);
    Resetn = 1'b1;
  endtask

  task automatic test_nominal_lock;
    bus.En = 1'b1;
    @(negedge Fin);
    pulse(64);
    checks++; if (vld_cnt !== 0) begin failures++; $display("FAIL nom_sync_edge: got %0d pulses expected 0", vld_cnt); end
    for (int k = 1; k <= 4; k++) begin
      pulse(64);
      checks++; if (vld_cnt !== 1) begin failures++; $display("FAIL nom_vld_%0d: got %0d pulses expected 1", k, vld_cnt); end
      checks++; if (meas_at !== 8'd64) begin failures++; $display("FAIL nom_meas_%0d: got %0d expected 64", k, meas_at); end
      checks++; if (locked_at !== (k == 4)) begin failures++; $display("FAIL nom_locked_%0d: got %b expected %b", k, locked_at, (k == 4)); end
    end
  endtask

  task automatic test_tolerance;
    pulse(66);
    pulse(62);
    checks++; if (meas_at !== 8'd66) begin failures++; $display("FAIL tol_meas66: got %0d expected 66", meas_at); end
    checks++; if (locked_at !== 1'b1) begin failures++; $display("FAIL tol_locked66: got %b expected 1", locked_at); end
    pulse(64);
    checks++; if (meas_at !== 8'd62) begin failures++; $display("FAIL tol_meas62: got %0d expected 62", meas_at); end
    checks++; if (locked_at !== 1'b1) begin failures++; $display("FAIL tol_locked62: got %b expected 1", locked_at); end
  endtask

  task automatic test_hysteresis;
    pulse(67);
    pulse(64);
    checks++; if (meas_at !== 8'd67) begin failures++; $display("FAIL hys_meas67: got %0d expected 67", meas_at); end
    checks++; if (locked_at !== 1'b1) begin failures++; $display("FAIL hys_single_bad: got %b expected 1", locked_at); end
    pulse(67);
    checks++; if (locked_at !== 1'b1) begin failures++; $display("FAIL hys_recover: got %b expected 1", locked_at); end
    pulse(67);
    checks++; if (locked_at !== 1'b1) begin failures++; $display("FAIL hys_bad1: got %b expected 1", locked_at); end
    pulse(64);
    checks++; if (locked_at !== 1'b0) begin failures++; $display("FAIL hys_bad2: got %b expected 0", locked_at); end
    for (int k = 1; k <= 4; k++) begin
      pulse(64);
      checks++; if (locked_at !== (k == 4)) begin failures++; $display("FAIL hys_relock_%0d: got %b expected %b", k, locked_at, (k == 4)); end
    end
  endtask

  task automatic test_max_period;
    pulse(255);
    pulse(64);
    checks++; if (vld_cnt !== 1) begin failures++; $display("FAIL max_vld: got %0d pulses expected 1", vld_cnt); end
    checks++; if (meas_at !== 8'd255) begin failures++; $display("FAIL max_meas: got %0d expected 255", meas_at); end
    checks++; if (rl_at !== 1'b0) begin failures++; $display("FAIL max_reflost: got %b expected 0", rl_at); end
    checks++; if (locked_at !== 1'b1) begin failures++; $display("FAIL max_locked: got %b expected 1", locked_at); end
  endtask

  task automatic test_ref_loss;
    pulse(400);
    checks++; if (vld_idx !== 2) begin failures++; $display("FAIL loss_edge_lat: got %0d expected 2", vld_idx); end
    checks++; if (rl_rise_idx !== 257) begin failures++; $display("FAIL loss_time: got %0d expected 257", rl_rise_idx); end
    checks++; if (bus.Locked !== 1'b0) begin failures++; $display("FAIL loss_locked: got %b expected 0", bus.Locked); end
    checks++; if (bus.Meas !== 8'd64) begin failures++; $display("FAIL loss_meas_hold: got %0d expected 64", bus.Meas); end
    pulse(64);
    checks++; if (vld_cnt !== 0) begin failures++; $display("FAIL loss_resync: got %0d pulses expected 0", vld_cnt); end
    checks++; if (bus.Ref_lost !== 1'b1) begin failures++; $display("FAIL loss_hold: got %b expected 1", bus.Ref_lost); end
    pulse(64);
    checks++; if (rl_at !== 1'b0) begin failures++; $display("FAIL loss_clear: got %b expected 0", rl_at); end
    checks++; if (meas_at !== 8'd64) begin failures++; $display("FAIL loss_meas: got %0d expected 64", meas_at); end
    for (int k = 2; k <= 4; k++) begin
      pulse(64);
      checks++; if (locked_at !== (k == 4)) begin failures++; $display("FAIL loss_relock_%0d: got %b expected %b", k, locked_at, (k == 4)); end
    end
  endtask

  task automatic test_enable;
    for (int i = 0; i < 10; i++) @(negedge Fin);
    bus.En = 1'b0;
    @(negedge Fin);
    checks++; if (bus.Locked !== 1'b0) begin failures++; $display("FAIL en_locked: got %b expected 0", bus.Locked); end
    checks++; if (bus.Meas !== 8'd64) begin failures++; $display("FAIL en_meas_hold: got %0d expected 64", bus.Meas); end
    pulse(64);
    pulse(64);
    checks++; if (vld_cnt !== 0) begin failures++; $display("FAIL en_off_vld: got %0d pulses expected 0", vld_cnt); end
    bus.En = 1'b1;
    pulse(64);
    checks++; if (vld_cnt !== 0) begin failures++; $display("FAIL en_resync: got %0d pulses expected 0", vld_cnt); end
    for (int k = 1; k <= 4; k++) begin
      pulse(64);
      checks++; if (locked_at !== (k == 4)) begin failures++; $display("FAIL en_relock_%0d: got %b expected %b", k, locked_at, (k == 4)); end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 20; i++) @(negedge Fin);
    checks++; if (bus.Locked !== 1'b1) begin failures++; $display("FAIL rmid_pre_locked: got %b expected 1", bus.Locked); end
    #2 Resetn = 1'b0;
    #1;
    checks++; if (bus.Locked !== 1'b0) begin failures++; $display("FAIL rmid_locked: got %b expected 0", bus.Locked); end
    checks++; if (bus.Meas !== 8'd0) begin failures++; $display("FAIL rmid_meas: got %0d expected 0", bus.Meas); end
    checks++; if (bus.Meas_valid !== 1'b0) begin failures++; $display("FAIL rmid_vld: got %b expected 0", bus.Meas_valid); end
    checks++; if (bus.Ref_lost !== 1'b0) begin failures++; $display("FAIL rmid_reflost: got %b expected 0", bus.Ref_lost); end
    @(negedge Fin);
    Resetn = 1'b1;
    pulse(64);
    checks++; if (vld_cnt !== 0) begin failures++; $display("FAIL rmid_resync: got %0d pulses expected 0", vld_cnt); end
    for (int k = 1; k <= 4; k++) begin
      pulse(64);
      checks++; if (locked_at !== (k == 4)) begin failures++; $display("FAIL rmid_relock_%0d: got %b expected %b", k, locked_at, (k == 4)); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal_lock();
    test_tolerance();
    test_hysteresis();
    test_max_period();
    test_ref_loss();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
